// File: rtl/mux_nx1_stream_if.sv
// Stream bundle between N producers, the multiplexer and one consumer.
// The slave modport is the multiplexer's view; master is the environment's view.
interface mux_nx1_stream_if #(
  parameter int N = 4,
  parameter int W = 8
);
  localparam int SW = (N > 1) ? $clog2(N) : 1;

  logic [N*W-1:0] in_data;
  logic [N-1:0]   in_valid;
  logic [N-1:0]   out_up_ready;
  logic [SW-1:0]  in_s;
  logic [W-1:0]   out_data;
  logic           out_valid;
  logic           in_dn_ready;
  logic [SW-1:0]  out_grant;

  modport slave (
    input  in_data, in_valid, in_s, in_dn_ready,
    output out_up_ready, out_data, out_valid, out_grant
  );

  modport master (
    output in_data, in_valid, in_s, in_dn_ready,
    input  out_up_ready, out_data, out_valid, out_grant
  );
endinterface

// File: rtl/mux_nx1_stream.sv
// Registered N:1 stream multiplexer with per-channel valid/ready handshake.
// MODE 0 picks the channel named by in_s; MODE 1 arbitrates round-robin
// among valid channels. One output register decouples the consumer.
module mux_nx1_stream #(
  parameter int N    = 4,
  parameter int W    = 8,
  parameter int MODE = 0
) (
  input logic                in_clk,
  input logic                in_rst_n,
  mux_nx1_stream_if.slave    bus
);
  localparam int SW = (N > 1) ? $clog2(N) : 1;

  logic          r_valid;
  logic [W-1:0]  r_data;
  logic [SW-1:0] r_grant;

  logic          w_loadEn;
  logic          w_hit;
  logic [SW-1:0] w_sel;
  logic [N-1:0]  w_upReady;

  // The register can take a word when empty or when its word leaves this cycle.
  assign w_loadEn = !r_valid || bus.in_dn_ready;

  generate
    if (MODE == 0) begin : gSelect
      // External select: out-of-range select values never produce a hit.
      always_comb begin
        w_sel = bus.in_s;
        w_hit = 1'b0;
        if (int'(bus.in_s) < N) w_hit = bus.in_valid[bus.in_s];
      end
    end else begin : gRoundRobin
      logic [SW-1:0] r_rrLast;

      // Scan starts just after the last granted channel so every channel gets a turn.
      always_comb begin
        w_sel = '0;
        w_hit = 1'b0;
        for (int k = 1; k <= N; k++) begin
          if (!w_hit && bus.in_valid[(int'(r_rrLast) + k) % N]) begin
            w_sel = SW'((int'(r_rrLast) + k) % N);
            w_hit = 1'b1;
          end
        end
      end

      // Remember the granted channel only when a word actually moves.
      always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
          r_rrLast <= SW'(N - 1);
        end else if (w_loadEn && w_hit) begin
          r_rrLast <= w_sel;
        end
      end
    end
  endgenerate

  // One-hot ready towards the selected producer; nothing handshakes during reset.
  always_comb begin
    w_upReady = '0;
    if (in_rst_n && w_loadEn && w_hit) w_upReady[w_sel] = 1'b1;
  end

  // Output stage: refill on a hit, empty on a drain, hold while stalled.
  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_grant <= '0;
    end else if (w_loadEn) begin
      if (w_hit) begin
        r_valid <= 1'b1;
        r_data  <= bus.in_data[w_sel*W +: W];
        r_grant <= w_sel;
      end else begin
        r_valid <= 1'b0;
      end
    end
  end

  assign bus.out_up_ready = w_upReady;
  assign bus.out_data     = r_data;
  assign bus.out_valid    = r_valid;
  assign bus.out_grant    = r_grant;
endmodule

// File: tb/tb_mux_nx1_stream.sv
// Bench for mux_nx1_stream: three instances (select N=4, select N=3,
// round-robin N=4) driven side by side, checked against a reference model
// that predicts each accepted word and a monitor that compares every word
// the DUT presents.
module tb_mux_nx1_stream;
  typedef struct packed {
    logic [7:0] d;
    logic [1:0] g;
  } exp_t;

  logic clock  = 1'b0;
  logic resetN = 1'b0;

  logic [31:0] drvData  [3];
  logic [3:0]  drvValid [3];
  logic [1:0]  drvS     [3];
  logic        drvDn    [3];

  logic [3:0]  obsUp [3];
  logic [7:0]  obsOd [3];
  logic [1:0]  obsOg [3];
  logic        obsOv [3];

  exp_t sb0[$];
  exp_t sb1[$];
  exp_t sb2[$];

  bit mv [3];
  int rr [3];
  int total = 0;
  int bad   = 0;

  // Free-running clock, period 10.
  always #5 clock = ~clock;

  mux_nx1_stream_if #(.N(4), .W(8)) ifA ();
  mux_nx1_stream_if #(.N(3), .W(8)) ifB ();
  mux_nx1_stream_if #(.N(4), .W(8)) ifC ();

  mux_nx1_stream #(.N(4), .W(8), .MODE(0)) dutA (.in_clk(clock), .in_rst_n(resetN), .bus(ifA));
  mux_nx1_stream #(.N(3), .W(8), .MODE(0)) dutB (.in_clk(clock), .in_rst_n(resetN), .bus(ifB));
  mux_nx1_stream #(.N(4), .W(8), .MODE(1)) dutC (.in_clk(clock), .in_rst_n(resetN), .bus(ifC));

  assign ifA.in_data     = drvData[0];
  assign ifA.in_valid    = drvValid[0];
  assign ifA.in_s        = drvS[0];
  assign ifA.in_dn_ready = drvDn[0];
  assign ifB.in_data     = drvData[1][23:0];
  assign ifB.in_valid    = drvValid[1][2:0];
  assign ifB.in_s        = drvS[1];
  assign ifB.in_dn_ready = drvDn[1];
  assign ifC.in_data     = drvData[2];
  assign ifC.in_valid    = drvValid[2];
  assign ifC.in_s        = drvS[2];
  assign ifC.in_dn_ready = drvDn[2];

  assign obsUp[0] = ifA.out_up_ready;
  assign obsUp[1] = {1'b0, ifB.out_up_ready};
  assign obsUp[2] = ifC.out_up_ready;
  assign obsOd[0] = ifA.out_data;
  assign obsOd[1] = ifB.out_data;
  assign obsOd[2] = ifC.out_data;
  assign obsOg[0] = ifA.out_grant;
  assign obsOg[1] = ifB.out_grant;
  assign obsOg[2] = ifC.out_grant;
  assign obsOv[0] = ifA.out_valid;
  assign obsOv[1] = ifB.out_valid;
  assign obsOv[2] = ifC.out_valid;

  function automatic int nOf(input int k);
    return (k == 1) ? 3 : 4;
  endfunction

  function automatic int modeOf(input int k);
    return (k == 2) ? 1 : 0;
  endfunction

  function automatic int sbSize(input int k);
    case (k)
      0: return sb0.size();
      1: return sb1.size();
      default: return sb2.size();
    endcase
  endfunction

  function automatic exp_t sbFront(input int k);
    case (k)
      0: return sb0[0];
      1: return sb1[0];
      default: return sb2[0];
    endcase
  endfunction

  function automatic void sbPush(input int k, input exp_t e);
    case (k)
      0: sb0.push_back(e);
      1: sb1.push_back(e);
      default: sb2.push_back(e);
    endcase
  endfunction

  function automatic void sbPop(input int k);
    exp_t e;
    case (k)
      0: e = sb0.pop_front();
      1: e = sb1.pop_front();
      default: e = sb2.pop_front();
    endcase
  endfunction

  // Which channel the rules choose: direct select, or first valid channel after the last grant.
  function automatic void pick(input int k, input logic [3:0] valid, input int s, input int rrLast,
                               output int sel, output bit hit);
    int n;
    n   = nOf(k);
    sel = 0;
    hit = 1'b0;
    if (modeOf(k) == 0) begin
      sel = s;
      hit = (s < n) && (valid[s] == 1'b1);
    end else begin
      for (int j = 1; j <= n; j++) begin
        int c;
        c = (rrLast + j) % n;
        if (!hit && valid[c]) begin
          sel = c;
          hit = 1'b1;
        end
      end
    end
  endfunction

  task automatic check(input string name, input int k, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("[TB] FAIL %s dut%0d: got %0h expected %0h at %0t", name, k, act, expv, $time);
    end
  endtask

  // Predicts handshakes for the inputs currently applied, then advances one clock.
  task automatic applyStimulus();
    int sel;
    bit hit;
    bit le;
    logic [3:0] expUp;
    bit nMv [3];
    int nRr [3];
    exp_t e;
    @(negedge clock);
    for (int k = 0; k < 3; k++) begin
      nMv[k] = mv[k];
      nRr[k] = rr[k];
      if (!resetN) begin
        check("upReadyInReset", k, 32'(obsUp[k]), 32'd0);
        continue;
      end
      le = !mv[k] || drvDn[k];
      pick(k, drvValid[k], int'(drvS[k]), rr[k], sel, hit);
      expUp = (le && hit) ? 4'(1 << sel) : 4'd0;
      check("upReady", k, 32'(obsUp[k]), 32'(expUp));
      check("outValid", k, 32'(obsOv[k]), 32'(mv[k]));
      if (le && hit) begin
        e.d = drvData[k][sel*8 +: 8];
        e.g = 2'(sel);
        sbPush(k, e);
        nMv[k] = 1'b1;
        if (modeOf(k) == 1) nRr[k] = sel;
      end else if (le) begin
        nMv[k] = 1'b0;
      end
    end
    @(posedge clock);
    for (int k = 0; k < 3; k++) begin
      mv[k] = nMv[k];
      rr[k] = nRr[k];
    end
    #1;
  endtask

  // Compares the word on the output against the oldest predicted word; retires it when consumed.
  task automatic checkOutput(input int k);
    exp_t e;
    if (!obsOv[k]) return;
    if (sbSize(k) == 0) begin
      total++;
      bad++;
      $display("[TB] FAIL unexpectedWord dut%0d: got data %0h grant %0d expected no word at %0t",
               k, obsOd[k], obsOg[k], $time);
      return;
    end
    e = sbFront(k);
    check("outData", k, 32'(obsOd[k]), 32'(e.d));
    check("outGrant", k, 32'(obsOg[k]), 32'(e.g));
    if (drvDn[k]) sbPop(k);
  endtask

  // Monitor runs on the falling edge, independent of the stimulus process.
  always @(negedge clock) begin
    if (resetN) begin
      for (int k = 0; k < 3; k++) checkOutput(k);
    end
  end

  task automatic modelReset();
    for (int k = 0; k < 3; k++) begin
      mv[k] = 1'b0;
      rr[k] = nOf(k) - 1;
    end
    sb0.delete();
    sb1.delete();
    sb2.delete();
  endtask

  task automatic checkResetState(input string tag);
    for (int k = 0; k < 3; k++) begin
      check({tag, "Valid"}, k, 32'(obsOv[k]), 32'd0);
      check({tag, "Data"}, k, 32'(obsOd[k]), 32'd0);
      check({tag, "Grant"}, k, 32'(obsOg[k]), 32'd0);
    end
  endtask

  // Asynchronous reset between edges: outputs must clear without a clock.
  task automatic midReset();
    resetN = 1'b0;
    #1;
    checkResetState("midRst");
    modelReset();
    applyStimulus();
    applyStimulus();
    resetN = 1'b1;
  endtask

  task automatic idleAll();
    for (int k = 0; k < 3; k++) begin
      drvData[k]  = 32'h0;
      drvValid[k] = 4'h0;
      drvS[k]     = 2'd0;
      drvDn[k]    = 1'b1;
    end
  endtask

  initial begin
    idleAll();
    modelReset();
    #2;
    checkResetState("initRst");
    applyStimulus();
    applyStimulus();
    resetN = 1'b1;
    $display("[TB] reset released");

    // Select mode: channel 2 carries A5.
    drvS[0]     = 2'd2;
    drvValid[0] = 4'b0100;
    drvData[0]  = 32'h00A5_0000;
    applyStimulus();
    drvValid[0] = 4'b0000;
    applyStimulus();

    // N=3 select: load a word, then out-of-range select drains, then invalid channel.
    drvS[1]     = 2'd0;
    drvValid[1] = 4'b0111;
    drvData[1]  = 32'h0033_2211;
    applyStimulus();
    drvS[1] = 2'd3;
    repeat (3) applyStimulus();
    drvS[1]     = 2'd1;
    drvValid[1] = 4'b0101;
    repeat (2) applyStimulus();
    drvValid[1] = 4'b0000;

    // Round-robin fairness with all channels valid, starting from the reset pointer.
    drvValid[2] = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      drvData[2] = $urandom;
      applyStimulus();
    end
    // Sparse set across the wrap point: channels 1 and 3 only.
    drvValid[2] = 4'b1010;
    for (int i = 0; i < 3; i++) begin
      drvData[2] = $urandom;
      applyStimulus();
    end
    drvValid[2] = 4'b0000;
    applyStimulus();

    // Backpressure: fill, stall five cycles with changing inputs, then release.
    for (int k = 0; k < 3; k++) begin
      drvValid[k] = 4'b1111;
      drvS[k]     = 2'(k);
      drvDn[k]    = 1'b1;
    end
    repeat (2) applyStimulus();
    for (int k = 0; k < 3; k++) drvDn[k] = 1'b0;
    for (int i = 0; i < 5; i++) begin
      for (int k = 0; k < 3; k++) begin
        drvData[k] = $urandom;
        drvS[k]    = 2'($urandom);
      end
      applyStimulus();
    end
    for (int k = 0; k < 3; k++) drvDn[k] = 1'b1;
    repeat (3) applyStimulus();
    midReset();

    // Randomised traffic with a reset in the middle.
    for (int i = 0; i < 300; i++) begin
      for (int k = 0; k < 3; k++) begin
        drvData[k]  = $urandom;
        drvValid[k] = 4'($urandom);
        drvS[k]     = 2'($urandom);
        drvDn[k]    = ($urandom_range(3, 0) != 0);
      end
      applyStimulus();
      if (i == 150) midReset();
    end

    // Drain everything and confirm every predicted word was seen.
    idleAll();
    repeat (3) applyStimulus();
    for (int k = 0; k < 3; k++) check("sbEmpty", k, 32'(sbSize(k)), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
